bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one port of a dual-port block RAM (RAMB16_S*_S* wrappers, 1-cycle sync read) among
//  NUM_REQ requesters with round-robin arbitration. Provides an optional post-reset clear sweep.
//  Returns read data to the granted requester. Sits between pipeline stages and the RAM port.
// PARAMETERS
//  NUM_REQ         2    requester count, 2..8
//  ADDR_BITS       13   RAM address width (8K x 2 primitive)
//  DATA_BITS       2    RAM data width
//  CLEAR_ON_RESET  1    1: write zero to every address after reset before accepting requests
// PORTS
//  CLK            in   1                    clock; all logic rising-edge
//  reset_n        in   1                    async active-low reset
//  req_valid      in   NUM_REQ              per-requester request valid
//  req_ready      out  NUM_REQ              one-hot grant; transfer = valid & ready
//  req_we         in   NUM_REQ              1=write, 0=read
//  req_addr       in   NUM_REQ*ADDR_BITS    packed addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//  req_wdata      in   NUM_REQ*DATA_BITS    packed write data
//  rsp_valid      out  NUM_REQ              one-hot read-response strobe
//  rsp_data       out  DATA_BITS            read data, valid when any rsp_valid bit is set
//  ram_en         out  1                    to RAM EN
//  ram_we         out  1                    to RAM WE
//  ram_addr       out  ADDR_BITS            to RAM ADDR
//  ram_di         out  DATA_BITS            to RAM DI
//  ram_do         in   DATA_BITS            from RAM DO
//  clear_done     out  1                    high once clear sweep is finished (or immediately if CLEAR_ON_RESET=0)
// BEHAVIOUR
//  - Reset: req_ready=0, rsp_valid=0, ram_en=0, ram_we=0, clear_done=0, RR pointer=0.
//    State is CLEAR if CLEAR_ON_RESET=1, else RUN. Reset mid-operation aborts everything; in-flight read is dropped.
//  - FSM CLEAR: ram_en=1, ram_we=1, ram_di=0, ram_addr counts 0..2^ADDR_BITS-1, one address/cycle.
//    req_ready=0 throughout. After the last address: -> RUN, clear_done=1 (registered).
//  - FSM RUN: combinational grant each cycle among req_valid, starting from the RR pointer (highest priority).
//    Grant g drives ram_en=1, ram_we=req_we[g], ram_addr/ram_di from slot g. No valid requests: ram_en=0.
//  - RR pointer advances to g+1 (mod NUM_REQ) only on a transfer; it holds when the cycle is idle.
//    A continuously-valid requester waits at most NUM_REQ-1 transfers.
//  - req_ready may depend combinationally on req_valid; requesters must not make valid depend on ready.
//  - Read latency 1: read granted in cycle t -> rsp_valid[g]=1 and rsp_data=ram_do in cycle t+1.
//    There is no response backpressure. Writes produce no response.
//  - Back-to-back: one transfer per cycle sustained. A write then a read of the same address in the next
//    cycle returns the new data (RAM write_first).
//  - rsp_data = 0 when no rsp_valid bit is set.
// CONFIGURATION
//  - BRAM_ARB_PERF_EN defined: adds ports perf_grants (out, NUM_REQ*16) and perf_stalls (out, NUM_REQ*16).
//    Per requester: grants += transfer, stalls += valid&!ready.
//    16-bit saturating counters (stick at 16'hFFFF), cleared by reset, frozen during CLEAR.
//  - Undefined: these ports and counters are absent; the rest of the block is identical.
// STRUCTURE
//  - bram_arb_pkg: state enum {ST_CLEAR, ST_RUN}; localparam PERF_W=16; function rr_pick(valid, ptr) -> one-hot.
//  - Sub-module rr_arbiter (NUM_REQ): valid vector + advance strobe in -> one-hot grant out;
//    owns the pointer register. The top level owns the FSM, the clear counter, RAM muxing and the response tag register.
// TESTING
//  - Reset, CLEAR_ON_RESET=1: clear_done rises after exactly 8192 CLEAR cycles.
//    Read of addr 0x1ABC afterwards -> rsp_data=0.
//  - Req0 writes 0x0005<=2'b11; next cycle req0 reads 0x0005 -> rsp_valid=2'b01, rsp_data=2'b11 one cycle after grant.
//  - Both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1.
//    rsp_valid mirrors the grant order one cycle later.
//  - Only req1 valid for 3 cycles, then both valid -> req0 granted first (pointer=0 after req1's transfers).
//  - Assert reset_n low mid-read -> rsp_valid=0 next edge, FSM restarts CLEAR, clear_done=0.
//  - BRAM_ARB_PERF_EN: hold req0 valid while req1 owns priority for 1 cycle -> perf_stalls[0]=1;
//    force 70000 grants -> perf_grants saturates at 16'hFFFF.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared state type, widths and round-robin pick helper for bram_port_arbiter
package bram_arb_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam int PERF_W  = 16;
   localparam int MAX_REQ = 8;
   localparam int PTR_W   = 3;

   // One-hot select of the first valid slot at or after ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [PTR_W-1:0]   ptr,
                                                   input int                 n);
      logic [MAX_REQ-1:0] pick;
      logic               found;
      logic [PTR_W:0]     sum;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(n))
            sum = sum - (PTR_W+1)'(n);
         if (i < n && !found && valid[sum[PTR_W-1:0]]) begin
            pick[sum[PTR_W-1:0]] = 1'b1;
            found                = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the priority pointer
// Pointer moves past the granted slot only when advance (a completed transfer) is high.
module rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_next;
   logic [MAX_REQ-1:0] valid_ext;
   logic [MAX_REQ-1:0] pick;
   logic               unused_pick;

   always_comb begin
      valid_ext              = '0;
      valid_ext[NUM_REQ-1:0] = valid;
      pick                   = rr_pick(valid_ext, ptr, NUM_REQ);
   end

   assign grant       = pick[NUM_REQ-1:0];
   assign unused_pick = ^pick;

   always_comb begin
      ptr_next = ptr;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i])
            ptr_next = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr <= '0;
      else if (advance)
         ptr <= ptr_next;
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin share of one BRAM port with optional post-reset clear sweep
// Optional BRAM_ARB_PERF_EN adds per-requester saturating grant/stall counters.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_BITS      = 13,
   parameter int DATA_BITS      = 2,
   parameter int CLEAR_ON_RESET = 1
)(
   input  logic                           CLK,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_BITS-1:0]           rsp_data,
   output logic                           ram_en,
   output logic                           ram_we,
   output logic [ADDR_BITS-1:0]           ram_addr,
   output logic [DATA_BITS-1:0]           ram_di,
   input  logic [DATA_BITS-1:0]           ram_do,
`ifdef BRAM_ARB_PERF_EN
   output logic [NUM_REQ*PERF_W-1:0]      perf_grants,
   output logic [NUM_REQ*PERF_W-1:0]      perf_stalls,
`endif
   output logic                           clear_done
);

   state_t               state;
   logic                 armed;
   logic [ADDR_BITS-1:0] clr_addr;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   xfer;
   logic [NUM_REQ-1:0]   rsp_tag;
   logic                 live_run;

   // armed keeps the RAM port and grants quiet for the first cycle out of reset
   assign live_run  = armed && (state == ST_RUN);
   assign req_ready = live_run ? grant : '0;
   assign xfer      = req_valid & req_ready;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk     (CLK),
      .reset_n (reset_n),
      .valid   (req_valid),
      .advance (|xfer),
      .grant   (grant)
   );

   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_di   = '0;
      if (armed && state == ST_CLEAR) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = clr_addr;
      end else if (live_run) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               ram_en   = 1'b1;
               ram_we   = req_we[i];
               ram_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
               ram_di   = req_wdata[i*DATA_BITS +: DATA_BITS];
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         armed      <= 1'b0;
         clr_addr   <= '0;
         clear_done <= 1'b0;
         rsp_tag    <= '0;
      end else begin
         armed   <= 1'b1;
         rsp_tag <= xfer & ~req_we;
         case (state)
            ST_CLEAR: begin
               if (armed) begin
                  clr_addr <= clr_addr + ADDR_BITS'(1);
                  if (&clr_addr) begin
                     state      <= ST_RUN;
                     clear_done <= 1'b1;
                  end
               end
            end
            default: clear_done <= 1'b1;
         endcase
      end
   end

   assign rsp_valid = rsp_tag;
   assign rsp_data  = (|rsp_tag) ? ram_do : '0;

`ifdef BRAM_ARB_PERF_EN
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         perf_grants <= '0;
         perf_stalls <= '0;
      end else if (live_run) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i] && perf_grants[i*PERF_W +: PERF_W] != '1)
               perf_grants[i*PERF_W +: PERF_W] <= perf_grants[i*PERF_W +: PERF_W] + PERF_W'(1);
            if (req_valid[i] && !req_ready[i] && perf_stalls[i*PERF_W +: PERF_W] != '1)
               perf_stalls[i*PERF_W +: PERF_W] <= perf_stalls[i*PERF_W +: PERF_W] + PERF_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter
module tb_bram_port_arbiter;

   localparam int NR = 2;
   localparam int AB = 13;
   localparam int DB = 2;

   logic              CLK = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_we;
   logic [NR*AB-1:0]  req_addr;
   logic [NR*DB-1:0]  req_wdata;
   logic [NR-1:0]     rsp_valid;
   logic [DB-1:0]     rsp_data;
   logic              ram_en;
   logic              ram_we;
   logic [AB-1:0]     ram_addr;
   logic [DB-1:0]     ram_di;
   logic [DB-1:0]     ram_do;
   logic              clear_done;
`ifdef BRAM_ARB_PERF_EN
   logic [NR*16-1:0]  perf_grants;
   logic [NR*16-1:0]  perf_stalls;
`endif

   bram_port_arbiter #(
      .NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB), .CLEAR_ON_RESET(1)
   ) dut (
      .CLK(CLK), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
`ifdef BRAM_ARB_PERF_EN
      .perf_grants(perf_grants), .perf_stalls(perf_stalls),
`endif
      .clear_done(clear_done)
   );

   always #5 CLK = ~CLK;

   // write_first block RAM
   logic [DB-1:0] mem [0:(1<<AB)-1];
   always @(posedge CLK) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_di;
            ram_do        <= ram_di;
         end else begin
            ram_do <= mem[ram_addr];
         end
      end
   end

   typedef struct {
      logic [NR-1:0] tag;
      logic [DB-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   int            grant_q[$];
   logic [DB-1:0] shadow [0:(1<<AB)-1];
   int            checks   = 0;
   int            failures = 0;
   bit            mon_en   = 1'b0;
   int            model_ptr = 0;

   always @(negedge CLK) begin
      logic [NR-1:0] exp_tag;
      logic [DB-1:0] exp_data;
      logic [NR-1:0] exp_grant;
      exp_t          e;
      int            s;
      if (mon_en) begin
         exp_tag  = '0;
         exp_data = '0;
         if (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            exp_tag  = e.tag;
            exp_data = e.data;
         end
         checks++;
         if (rsp_valid !== exp_tag) begin
            failures++;
            $display("FAIL rsp_valid got=%b exp=%b t=%0t", rsp_valid, exp_tag, $time);
         end
         checks++;
         if (rsp_data !== exp_data) begin
            failures++;
            $display("FAIL rsp_data got=%b exp=%b t=%0t", rsp_data, exp_data, $time);
         end
         exp_grant = '0;
         for (int k = 0; k < NR; k++) begin
            s = (model_ptr + k) % NR;
            if (exp_grant == '0 && req_valid[s]) exp_grant[s] = 1'b1;
         end
         checks++;
         if (req_ready !== exp_grant) begin
            failures++;
            $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready, exp_grant, $time);
         end
         for (int k = 0; k < NR; k++) begin
            if (req_valid[k] && req_ready[k]) begin
               grant_q.push_back(k);
               model_ptr = (k + 1) % NR;
               if (req_we[k]) begin
                  shadow[req_addr[k*AB +: AB]] = req_wdata[k*DB +: DB];
               end else begin
                  e.tag    = '0;
                  e.tag[k] = 1'b1;
                  e.data   = shadow[req_addr[k*AB +: AB]];
                  exp_q.push_back(e);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input int i, input bit v, input bit we,
                          input logic [AB-1:0] a, input logic [DB-1:0] d);
      req_valid[i]          = v;
      req_we[i]             = we;
      req_addr[i*AB +: AB]  = a;
      req_wdata[i*DB +: DB] = d;
   endtask

   task automatic model_reset();
      for (int a = 0; a < (1<<AB); a++) shadow[a] = '0;
      model_ptr = 0;
      exp_q.delete();
      grant_q.delete();
   endtask

   task automatic wait_clear(output int writes, output int bad, output bit done);
      writes = 0;
      bad    = 0;
      done   = 1'b0;
      for (int c = 0; c < 9000 && !done; c++) begin
         @(negedge CLK);
         if (clear_done) done = 1'b1;
         else if (ram_en) begin
            if (ram_we === 1'b1 && ram_di === '0 && ram_addr === AB'(writes) && req_ready === '0)
               writes++;
            else
               bad++;
         end
      end
   endtask

   task automatic test_reset();
      int w, b;
      bit d;
      reset_n = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++; if (req_ready !== '0)   begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      checks++; if (rsp_valid !== '0)   begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (ram_en !== 1'b0)    begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
      checks++; if (ram_we !== 1'b0)    begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL reset_clear_done got=%b exp=0", clear_done); end
      step();
      reset_n = 1'b1;
      wait_clear(w, b, d);
      checks++; if (d !== 1'b1) begin failures++; $display("FAIL clear_timeout got=%0d exp=1", d); end
      checks++; if (w != 8192)  begin failures++; $display("FAIL clear_writes got=%0d exp=8192", w); end
      checks++; if (b != 0)     begin failures++; $display("FAIL clear_bad_cycles got=%0d exp=0", b); end
      model_reset();
      step();
      mon_en = 1'b1;
   endtask

   task automatic test_clear_readback();
      set_req(0, 1'b1, 1'b0, 13'h1ABC, 2'b00);
      @(negedge CLK);
      @(posedge CLK); #1;
      req_valid = '0;
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 2'b00) begin
         failures++;
         $display("FAIL clear_readback got=%b/%b exp=01/00", rsp_valid, rsp_data);
      end
      step();
   endtask

   task automatic test_write_read();
      set_req(0, 1'b1, 1'b1, 13'h0005, 2'b11);
      step();
      set_req(0, 1'b1, 1'b0, 13'h0005, 2'b00);
      step();
      req_valid = '0;
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 2'b11) begin
         failures++;
         $display("FAIL write_read got=%b/%b exp=01/11", rsp_valid, rsp_data);
      end
      step();
   endtask

   task automatic check_order(input string name, input int exp_order[$]);
      checks++;
      if (grant_q.size() != exp_order.size()) begin
         failures++;
         $display("FAIL %s_len got=%0d exp=%0d", name, grant_q.size(), exp_order.size());
      end else begin
         foreach (exp_order[k]) begin
            checks++;
            if (grant_q[k] != exp_order[k]) begin
               failures++;
               $display("FAIL %s[%0d] got=%0d exp=%0d", name, k, grant_q[k], exp_order[k]);
            end
         end
      end
   endtask

   task automatic test_req1_then_both();
      grant_q.delete();
      for (int c = 0; c < 3; c++) begin
         set_req(1, 1'b1, 1'b0, AB'(5 + c), 2'b00);
         step();
      end
      for (int c = 0; c < 4; c++) begin
         set_req(0, 1'b1, 1'b0, AB'(16 + c), 2'b00);
         set_req(1, 1'b1, 1'b0, AB'(5), 2'b00);
         step();
      end
      req_valid = '0;
      step(); step();
      check_order("req1_then_both", '{1, 1, 1, 0, 1, 0, 1});
   endtask

   task automatic test_alternate();
      grant_q.delete();
      for (int c = 0; c < 6; c++) begin
         set_req(0, 1'b1, 1'b1, 13'h0020, DB'(c));
         set_req(1, 1'b1, 1'b0, 13'h0020, 2'b00);
         step();
      end
      req_valid = '0;
      step(); step();
      check_order("alternate", '{0, 1, 0, 1, 0, 1});
   endtask

   task automatic test_back_to_back();
      int busy;
      grant_q.delete();
      busy = 0;
      for (int c = 0; c < 8; c++) begin
         set_req(0, 1'b1, 1'(c % 2 == 0), 13'h0100, DB'(c + 1));
         step();
      end
      for (int c = 0; c < 24; c++) begin
         for (int i = 0; i < NR; i++)
            set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AB'($urandom_range(0, 7)), DB'($urandom_range(0, 3)));
         if (req_valid != '0) busy++;
         step();
      end
      req_valid = '0;
      step(); step();
      checks++;
      if (grant_q.size() != 8 + busy) begin
         failures++;
         $display("FAIL back_to_back_grants got=%0d exp=%0d", grant_q.size(), 8 + busy);
      end
   endtask

   task automatic test_reset_mid_read();
      int w, b;
      bit d;
      mon_en = 1'b0;
      set_req(0, 1'b1, 1'b0, 13'h0005, 2'b00);
      @(negedge CLK);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midread_grant got=%b exp=01", req_ready); end
      reset_n   = 1'b0;
      req_valid = '0;
      @(posedge CLK); #1;
      checks++; if (rsp_valid !== '0)    begin failures++; $display("FAIL midread_rsp got=%b exp=0", rsp_valid); end
      checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL midread_clear_done got=%b exp=0", clear_done); end
      checks++; if (ram_en !== 1'b0)     begin failures++; $display("FAIL midread_ram_en got=%b exp=0", ram_en); end
      step(); step();
      reset_n = 1'b1;
      wait_clear(w, b, d);
      checks++; if (d !== 1'b1) begin failures++; $display("FAIL reclear_timeout got=%0d exp=1", d); end
      checks++; if (w != 8192)  begin failures++; $display("FAIL reclear_writes got=%0d exp=8192", w); end
      model_reset();
      step();
      mon_en = 1'b1;
   endtask

`ifdef BRAM_ARB_PERF_EN
   task automatic test_perf();
      @(negedge CLK);
      checks++; if (perf_grants !== '0) begin failures++; $display("FAIL perf_grants_reset got=%h exp=0", perf_grants); end
      checks++; if (perf_stalls !== '0) begin failures++; $display("FAIL perf_stalls_reset got=%h exp=0", perf_stalls); end
      step();
      set_req(0, 1'b1, 1'b1, 13'h0030, 2'b01);
      step();
      set_req(1, 1'b1, 1'b1, 13'h0031, 2'b10);
      step();
      req_valid = '0;
      step();
      @(negedge CLK);
      checks++; if (perf_stalls[15:0] !== 16'd1)  begin failures++; $display("FAIL perf_stall0 got=%0d exp=1", perf_stalls[15:0]); end
      checks++; if (perf_stalls[31:16] !== 16'd0) begin failures++; $display("FAIL perf_stall1 got=%0d exp=0", perf_stalls[31:16]); end
      checks++; if (perf_grants[15:0] !== 16'd1)  begin failures++; $display("FAIL perf_grant0 got=%0d exp=1", perf_grants[15:0]); end
      checks++; if (perf_grants[31:16] !== 16'd1) begin failures++; $display("FAIL perf_grant1 got=%0d exp=1", perf_grants[31:16]); end
      step();
      set_req(0, 1'b1, 1'b1, 13'h0040, 2'b10);
      repeat (70000) step();
      req_valid = '0;
      step();
      @(negedge CLK);
      checks++; if (perf_grants[15:0] !== 16'hFFFF) begin failures++; $display("FAIL perf_sat got=%h exp=ffff", perf_grants[15:0]); end
      checks++; if (perf_grants[31:16] !== 16'd1)   begin failures++; $display("FAIL perf_sat_other got=%0d exp=1", perf_grants[31:16]); end
      checks++; if (perf_stalls[15:0] !== 16'd1)    begin failures++; $display("FAIL perf_stall_hold got=%0d exp=1", perf_stalls[15:0]); end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_clear_readback();
      test_write_read();
      test_req1_then_both();
      test_alternate();
      test_back_to_back();
      test_reset_mid_read();
`ifdef BRAM_ARB_PERF_EN
      test_perf();
`endif
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
